// File: rtl/agc_gain_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// agc_pkg: shared definitions for the AGC gain-control stage.
//   - agc_state_e   : FSM states of the gain-control loop
//   - GAIN_STEP     : normal gain step size
//   - FAST_STEP     : fast-attack gain step size
//   - gain_step_sat : saturating add/sub of the gain word
// ---------------------------------------------------------------------------
package agc_pkg;

   typedef enum logic [1:0] {
      StAccum   = 2'd0,
      StCompare = 2'd1,
      StUpdate  = 2'd2
   } agc_state_e;

   localparam int unsigned GAIN_STEP = 1;
   localparam int unsigned FAST_STEP = 4;

   // Steps gain up or down by step, clamping to [0, gain_max]. Operates on a
   // 32-bit carrier so one function serves every gain width up to 31 bits.
   function automatic logic [31:0] gain_step_sat(input logic [31:0] gain,
                                                 input logic [31:0] step,
                                                 input logic        up,
                                                 input logic [31:0] gain_max);
      logic [32:0] sum;
      logic [31:0] res;
      sum = {1'b0, gain} + {1'b0, step};
      if (up) begin
         res = (sum > {1'b0, gain_max}) ? gain_max : sum[31:0];
      end else begin
         res = (gain < step) ? 32'd0 : gain - step;
      end
      return res;
   endfunction

endpackage

// File: rtl/agc_gain_ctrl_if.sv
// ---------------------------------------------------------------------------
// agc_gain_ctrl_if: sample/gain bus of the AGC gain-control stage.
//   valid, relation   : sample stream from the monopulse stage
//   ready             : sample accepted when valid && ready
//   setpoint          : target average magnitude
//   hysteresis        : half-width of the dead band
//   gain, gain_valid  : gain word and its per-window decision pulse
//   locked            : loop in-band for the required number of windows
// master modport = upstream/consumer side, slave modport = AGC block.
// ---------------------------------------------------------------------------
interface agc_gain_ctrl_if #(
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned GAIN_SIZE = 8
);

   logic                 valid;
   logic                 ready;
   logic [DATA_SIZE-1:0] relation;
   logic [DATA_SIZE-1:0] setpoint;
   logic [DATA_SIZE-1:0] hysteresis;
   logic [GAIN_SIZE-1:0] gain;
   logic                 gain_valid;
   logic                 locked;

   modport master (
      output valid, relation, setpoint, hysteresis,
      input  ready, gain, gain_valid, locked
   );

   modport slave (
      input  valid, relation, setpoint, hysteresis,
      output ready, gain, gain_valid, locked
   );

endinterface

// File: rtl/agc_window_accum.sv
// ---------------------------------------------------------------------------
// agc_window_accum: sums 2^WIN_LOG2 accepted samples and flags the last one.
//   i_clock       : clock, rising edge
//   i_reset       : asynchronous active-low reset
//   i_accept      : a sample is consumed this cycle
//   i_clear       : discard the accumulated window
//   i_relation    : sample value
//   o_avg         : accumulator >> WIN_LOG2
//   o_window_done : the sample accepted this cycle completes the window
// ---------------------------------------------------------------------------
module agc_window_accum #(
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned WIN_LOG2  = 4
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_accept,
   input  logic                 i_clear,
   input  logic [DATA_SIZE-1:0] i_relation,
   output logic [DATA_SIZE-1:0] o_avg,
   output logic                 o_window_done
);

   // WIN_LOG2 extra bits hold a full window of all-ones samples.
   localparam int unsigned AccW = DATA_SIZE + WIN_LOG2;

   logic [AccW-1:0]     acc_q;
   logic [WIN_LOG2-1:0] cnt_q;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (i_clear) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (i_accept) begin
         acc_q <= acc_q + AccW'(i_relation);
         cnt_q <= cnt_q + WIN_LOG2'(1);
      end
   end

   assign o_window_done = i_accept && (cnt_q == '1);
   assign o_avg         = acc_q[AccW-1:WIN_LOG2];

endmodule

// File: rtl/agc_gain_ctrl.sv
// ---------------------------------------------------------------------------
// agc_gain_ctrl: AGC loop stage. Averages the relation stream over
// 2^WIN_LOG2 samples, compares the average to setpoint +/- hysteresis and
// steps a saturating gain word; reports lock after LOCK_COUNT in-band windows.
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : agc_gain_ctrl_if.slave (valid/ready/relation in, setpoint,
//             hysteresis in, gain/gain_valid/locked out)
// Optional feature macro: AGC_FAST_ATTACK_EN -- when defined, an average above
// 2*setpoint steps the gain down by FAST_STEP instead of GAIN_STEP.
// ---------------------------------------------------------------------------
module agc_gain_ctrl
   import agc_pkg::*;
#(
   parameter int unsigned DATA_SIZE  = 64,
   parameter int unsigned GAIN_SIZE  = 8,
   parameter int unsigned GAIN_INIT  = 128,
   parameter int unsigned WIN_LOG2   = 4,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic          i_clock,
   input  logic          i_reset,
   agc_gain_ctrl_if.slave bus
);

   localparam int unsigned LockW   = $clog2(LOCK_COUNT + 1);
   localparam logic [31:0] GainMax = 32'((64'd1 << GAIN_SIZE) - 64'd1);

   agc_state_e           state_q;
   logic                 ready_q;
   logic                 gain_valid_q;
   logic                 locked_q;
   logic [GAIN_SIZE-1:0] gain_q, gain_d;
   logic [LockW-1:0]     lock_q, lock_d;
   logic [DATA_SIZE-1:0] avg_q, hi_q, lo_q;
   logic [DATA_SIZE-1:0] win_avg, hi_sat, lo_sat;
   logic [DATA_SIZE:0]   hi_sum;
   logic                 accept, window_done, win_clear;
`ifdef AGC_FAST_ATTACK_EN
   logic [DATA_SIZE:0]   sp2_q;
`endif

   assign accept    = bus.valid && ready_q;
   assign win_clear = (state_q == StUpdate);

   agc_window_accum #(
      .DATA_SIZE (DATA_SIZE),
      .WIN_LOG2  (WIN_LOG2)
   ) u_accum (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_accept      (accept),
      .i_clear       (win_clear),
      .i_relation    (bus.relation),
      .o_avg         (win_avg),
      .o_window_done (window_done)
   );

   // Dead-band edges, clamped so the band never wraps.
   assign hi_sum = {1'b0, bus.setpoint} + {1'b0, bus.hysteresis};
   assign hi_sat = hi_sum[DATA_SIZE] ? '1 : hi_sum[DATA_SIZE-1:0];
   assign lo_sat = (bus.setpoint >= bus.hysteresis) ? bus.setpoint - bus.hysteresis : '0;

   // Window decision, consumed only in StUpdate.
   always_comb begin
      gain_d = gain_q;
      lock_d = lock_q;
`ifdef AGC_FAST_ATTACK_EN
      if ({1'b0, avg_q} > sp2_q) begin
         gain_d = GAIN_SIZE'(gain_step_sat(32'(gain_q), FAST_STEP, 1'b0, GainMax));
         lock_d = '0;
      end else
`endif
      if (avg_q > hi_q) begin
         gain_d = GAIN_SIZE'(gain_step_sat(32'(gain_q), GAIN_STEP, 1'b0, GainMax));
         lock_d = '0;
      end else if (avg_q < lo_q) begin
         gain_d = GAIN_SIZE'(gain_step_sat(32'(gain_q), GAIN_STEP, 1'b1, GainMax));
         lock_d = '0;
      end else if (lock_q != LockW'(LOCK_COUNT)) begin
         lock_d = lock_q + LockW'(1);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= StAccum;
         ready_q      <= 1'b1;
         gain_q       <= GAIN_SIZE'(GAIN_INIT);
         gain_valid_q <= 1'b0;
         lock_q       <= '0;
         locked_q     <= 1'b0;
         avg_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
`ifdef AGC_FAST_ATTACK_EN
         sp2_q        <= '0;
`endif
      end else begin
         gain_valid_q <= 1'b0;
         unique case (state_q)
            StAccum: begin
               if (window_done) begin
                  state_q <= StCompare;
                  ready_q <= 1'b0;
               end
            end
            StCompare: begin
               // Setpoint and hysteresis are sampled only here.
               avg_q   <= win_avg;
               hi_q    <= hi_sat;
               lo_q    <= lo_sat;
`ifdef AGC_FAST_ATTACK_EN
               sp2_q   <= {bus.setpoint, 1'b0};
`endif
               state_q <= StUpdate;
            end
            StUpdate: begin
               gain_q       <= gain_d;
               lock_q       <= lock_d;
               locked_q     <= (lock_d == LockW'(LOCK_COUNT));
               gain_valid_q <= 1'b1;
               ready_q      <= 1'b1;
               state_q      <= StAccum;
            end
            default: begin
               state_q <= StAccum;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.gain       = gain_q;
   assign bus.gain_valid = gain_valid_q;
   assign bus.locked     = locked_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_agc_gain_ctrl: directed bench for agc_gain_ctrl with default parameters,
// setpoint 1000, hysteresis 100 (band 900..1100). Two extra instances with
// GAIN_INIT 255 and 0 cover gain saturation.
// ---------------------------------------------------------------------------
module tb_agc_gain_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   agc_gain_ctrl_if #(.DATA_SIZE(64), .GAIN_SIZE(8)) m_if ();
   agc_gain_ctrl_if #(.DATA_SIZE(64), .GAIN_SIZE(8)) a_if ();
   agc_gain_ctrl_if #(.DATA_SIZE(64), .GAIN_SIZE(8)) b_if ();

   agc_gain_ctrl #(.GAIN_INIT(128)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (m_if)
   );

   agc_gain_ctrl #(.GAIN_INIT(255)) dut_max (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (a_if)
   );

   agc_gain_ctrl #(.GAIN_INIT(0)) dut_min (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (b_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Feeds one 16-sample window; returns at the negedge after the COMPARE edge.
   task automatic feed(input string tag, input logic [63:0] v, input bit aux, input bit hold);
      int gv_seen;
      gv_seen = 0;
      @(negedge clk);
      chk({tag, "/ready_start"}, 64'(m_if.ready), 64'd1);
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge clk);
         if (m_if.gain_valid) gv_seen++;
         m_if.valid    = 1'b1;
         m_if.relation = v;
         a_if.valid    = aux;
         a_if.relation = 64'd0;
         b_if.valid    = aux;
         b_if.relation = 64'd5000;
         @(posedge clk);
      end
      @(negedge clk);
      if (hold) m_if.relation = 64'd1_000_000;
      else m_if.valid = 1'b0;
      a_if.valid = 1'b0;
      b_if.valid = 1'b0;
      chk({tag, "/no_early_pulse"}, 64'(gv_seen), 64'd0);
      chk({tag, "/ready_n"}, 64'(m_if.ready), 64'd0);
      @(negedge clk);
      chk({tag, "/ready_n1"}, 64'(m_if.ready), 64'd0);
      chk({tag, "/gv_n1"}, 64'(m_if.gain_valid), 64'd0);
   endtask

   // Checks the decision edge N+2 and the cycle after it.
   task automatic decide(input string tag, input logic [7:0] g, input logic lk, input bit aux);
      @(negedge clk);
      m_if.valid = 1'b0;
      chk({tag, "/gv"}, 64'(m_if.gain_valid), 64'd1);
      chk({tag, "/gain"}, 64'(m_if.gain), 64'(g));
      chk({tag, "/locked"}, 64'(m_if.locked), 64'(lk));
      chk({tag, "/ready"}, 64'(m_if.ready), 64'd1);
      if (aux) begin
         chk({tag, "/max_gv"}, 64'(a_if.gain_valid), 64'd1);
         chk({tag, "/max_gain"}, 64'(a_if.gain), 64'd255);
         chk({tag, "/min_gv"}, 64'(b_if.gain_valid), 64'd1);
         chk({tag, "/min_gain"}, 64'(b_if.gain), 64'd0);
      end
      @(negedge clk);
      chk({tag, "/gv_off"}, 64'(m_if.gain_valid), 64'd0);
      chk({tag, "/gain_hold"}, 64'(m_if.gain), 64'(g));
   endtask

   initial begin
      m_if.valid = 1'b0; m_if.relation = '0; m_if.setpoint = 64'd1000; m_if.hysteresis = 64'd100;
      a_if.valid = 1'b0; a_if.relation = '0; a_if.setpoint = 64'd1000; a_if.hysteresis = 64'd100;
      b_if.valid = 1'b0; b_if.relation = '0; b_if.setpoint = 64'd1000; b_if.hysteresis = 64'd100;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst/gain", 64'(m_if.gain), 64'd128);
      chk("rst/gv", 64'(m_if.gain_valid), 64'd0);
      chk("rst/locked", 64'(m_if.locked), 64'd0);
      chk("rst/ready", 64'(m_if.ready), 64'd1);
      chk("rst/max_gain", 64'(a_if.gain), 64'd255);
      chk("rst/min_gain", 64'(b_if.gain), 64'd0);

      // In-band windows: gain holds, lock after the fourth.
      feed("w1", 64'd1000, 1'b1, 1'b0); decide("w1", 8'd128, 1'b0, 1'b1);
      feed("w2", 64'd1000, 1'b0, 1'b0); decide("w2", 8'd128, 1'b0, 1'b0);
      feed("w3", 64'd1000, 1'b0, 1'b0); decide("w3", 8'd128, 1'b0, 1'b0);
      feed("w4", 64'd1000, 1'b0, 1'b0); decide("w4", 8'd128, 1'b1, 1'b0);

      // Below band from lock: gain up, lock drops on the decision edge.
      feed("w5", 64'd500, 1'b0, 1'b0);
      chk("w5/locked_before", 64'(m_if.locked), 64'd1);
      decide("w5", 8'd129, 1'b0, 1'b0);

      feed("w6", 64'd1500, 1'b0, 1'b0); decide("w6", 8'd128, 1'b0, 1'b0);

      feed("w7", 64'd3000, 1'b0, 1'b0);
`ifdef AGC_FAST_ATTACK_EN
      decide("w7", 8'd124, 1'b0, 1'b0);
`else
      decide("w7", 8'd127, 1'b0, 1'b0);
`endif

      // Reset after 7 samples of a window.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         m_if.valid    = 1'b1;
         m_if.relation = 64'd500;
         @(posedge clk);
      end
      #2;
      rst_n      = 1'b0;
      m_if.valid = 1'b0;
      #1;
      chk("mid_rst/gain", 64'(m_if.gain), 64'd128);
      chk("mid_rst/ready", 64'(m_if.ready), 64'd1);
      chk("mid_rst/gv", 64'(m_if.gain_valid), 64'd0);
      chk("mid_rst/locked", 64'(m_if.locked), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      feed("w8", 64'd500, 1'b0, 1'b0); decide("w8", 8'd129, 1'b0, 1'b0);

      // valid held high with a large value through COMPARE/UPDATE.
      feed("w9", 64'd1000, 1'b0, 1'b1); decide("w9", 8'd129, 1'b0, 1'b0);
      feed("w10", 64'd1000, 1'b0, 1'b0); decide("w10", 8'd129, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
